// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point radix-2 DIT FFT sequencer.
// Latency: none (package only).
// Backpressure: none (package only).
package fft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int TW_W  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    STALL,
    UNLOAD
  } state_t;

  // One butterfly command as it travels down the write-back delay line.
  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
  } bf_cmd_t;

  // Bit-reversed order of a 3-bit sample index.
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2]};
  endfunction

endpackage

// File: rtl/fft8_wb_delay.sv
// Delay line that tracks each butterfly command to its write-back slot.
// Latency: exactly BF_LAT cycles from input to output.
// Backpressure: none; shifts every cycle, cleared asynchronously by rst.
module fft8_wb_delay
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [LOG2N-1:0] d_addr_a,
  input  logic [LOG2N-1:0] d_addr_b,
  output logic             q_valid,
  output logic [LOG2N-1:0] q_addr_a,
  output logic [LOG2N-1:0] q_addr_b
);

  bf_cmd_t [BF_LAT-1:0] pipe;

  // Shift the command through BF_LAT stages; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{vld: d_valid, addr_a: d_addr_a, addr_b: d_addr_b};
      for (int i = 1; i < BF_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q_valid  = pipe[BF_LAT-1].vld;
  assign q_addr_a = pipe[BF_LAT-1].addr_a;
  assign q_addr_b = pipe[BF_LAT-1].addr_b;

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Sequencer for an 8-point DIT FFT: bit-reversed load, 3x4 butterflies, natural-order unload.
// Latency: compute phase is 3*(4+BF_LAT) cycles; done pulses one cycle after the last output beat.
// Backpressure: load advances on in_valid, unload holds on out_ready=0; inverse/tw_conj exist only with FFT8_SEQ_CTRL_IFFT_EN.
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef FFT8_SEQ_CTRL_IFFT_EN
  input  logic             inverse,
  output logic             tw_conj,
`endif
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [LOG2N-1:0] mem_waddr,
  output logic             bf_valid,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [TW_W-1:0]  tw_idx,
  output logic [1:0]       stage,
  output logic             wb_valid,
  output logic [LOG2N-1:0] wb_addr_a,
  output logic [LOG2N-1:0] wb_addr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_addr,
  output logic             out_last
);

  localparam logic [2:0] STALL_LAST = 3'(BF_LAT - 1);

  state_t           state;
  logic [LOG2N-1:0] ld_idx;
  logic [1:0]       bf_k;
  logic [1:0]       stage_q;
  logic [2:0]       stall_cnt;
  logic [LOG2N-1:0] rd_addr;
  logic             done_q;
`ifdef FFT8_SEQ_CTRL_IFFT_EN
  logic             inv_q;
`endif

  // Sequencing FSM: owns every counter so an abort by rst leaves nothing half-updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ld_idx    <= '0;
      bf_k      <= '0;
      stage_q   <= '0;
      stall_cnt <= '0;
      rd_addr   <= '0;
      done_q    <= 1'b0;
`ifdef FFT8_SEQ_CTRL_IFFT_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ld_idx  <= '0;
            stage_q <= '0;
`ifdef FFT8_SEQ_CTRL_IFFT_EN
            inv_q   <= inverse;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            ld_idx <= ld_idx + 3'd1;
            if (ld_idx == 3'(N - 1)) begin
              state   <= COMPUTE;
              bf_k    <= '0;
              stage_q <= '0;
            end
          end
        end
        COMPUTE: begin
          bf_k <= bf_k + 2'd1;
          if (bf_k == 2'd3) begin
            state     <= STALL;
            stall_cnt <= '0;
          end
        end
        STALL: begin
          // The last write-back of the stage lands in the final stall cycle,
          // so the next stage never reads a location still in flight.
          stall_cnt <= stall_cnt + 3'd1;
          if (stall_cnt == STALL_LAST) begin
            if (stage_q == 2'd2) begin
              state   <= UNLOAD;
              rd_addr <= '0;
            end else begin
              state   <= COMPUTE;
              stage_q <= stage_q + 2'd1;
              bf_k    <= '0;
            end
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            rd_addr <= rd_addr + 3'd1;
            if (rd_addr == 3'(N - 1)) begin
              state   <= IDLE;
              done_q  <= 1'b1;
              stage_q <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [2:0] k3, span, a_raw, b_raw;
  logic [1:0] tw_raw;

  // Butterfly operand addresses and twiddle index for (stage_q, bf_k).
  always_comb begin
    k3     = {1'b0, bf_k};
    span   = 3'd1 << stage_q;
    a_raw  = ((k3 >> stage_q) << (stage_q + 2'd1)) | (k3 & (span - 3'd1));
    b_raw  = a_raw + span;
    tw_raw = (bf_k & (span[1:0] - 2'd1)) << (2'd2 - stage_q);
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign in_ready  = (state == LOAD);
  assign mem_we    = in_valid & in_ready;
  assign mem_waddr = in_ready ? bitrev3(ld_idx) : '0;
  assign bf_valid  = (state == COMPUTE);
  assign bf_addr_a = bf_valid ? a_raw : '0;
  assign bf_addr_b = bf_valid ? b_raw : '0;
  assign tw_idx    = bf_valid ? tw_raw : '0;
  assign stage     = stage_q;
  assign out_valid = (state == UNLOAD);
  assign out_addr  = rd_addr;
  assign out_last  = out_valid & (rd_addr == 3'(N - 1));
`ifdef FFT8_SEQ_CTRL_IFFT_EN
  assign tw_conj   = bf_valid & inv_q;
`endif

  fft8_wb_delay #(.BF_LAT(BF_LAT)) u_wb_delay (
    .clk      (clk),
    .rst      (rst),
    .d_valid  (bf_valid),
    .d_addr_a (bf_addr_a),
    .d_addr_b (bf_addr_b),
    .q_valid  (wb_valid),
    .q_addr_a (wb_addr_a),
    .q_addr_b (wb_addr_b)
  );

endmodule
